// File: rtl/fc_pkg.sv
// Shared widths, FSM encoding and the (index, value) record used by the top-2 scan.
// No logic, so no latency.
// No handshake of its own; it only supplies types and constants.
package fc_pkg;

    localparam int DW = 16;
    localparam int IW = 12;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    localparam logic [IW-1:0] NO_IDX  = {IW{1'b1}};
    localparam logic [DW-1:0] NEG_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef struct packed {
        logic        [IW-1:0] idx;
        logic signed [DW-1:0] val;
    } entry_t;

endpackage

// File: rtl/fc_top2_update.sv
// Folds one new (index, value) into a running best/second pair using strict signed compares.
// Purely combinational, so the updated pair is available in the same cycle.
// No handshake; the caller decides when to register the result.
module fc_top2_update
    import fc_pkg::*;
(
    input  entry_t                best_in,
    input  entry_t                second_in,
    input  logic     [IW-1:0]     new_idx,
    input  logic     [DW-1:0]     new_val,
    output entry_t                best_out,
    output entry_t                second_out
);

    // A strict greater-than means that on a tie the entry seen first keeps its place.
    always_comb begin
        best_out   = best_in;
        second_out = second_in;
        if ($signed(new_val) > $signed(best_in.val)) begin
            second_out = best_in;
            best_out   = '{idx: new_idx, val: new_val};
        end else if ($signed(new_val) > $signed(second_in.val)) begin
            second_out = '{idx: new_idx, val: new_val};
        end
    end

endmodule

// File: rtl/fc_argmax.sv
// Scans one cout-beat vector of signed activations and reports the top-2 classes (index and value).
// The result is valid one cycle after the last beat is accepted; beats are accepted at 1 per cycle.
// din_ready drops only while a result waits; the result is held until res_ready is seen.
module fc_argmax #(
    parameter int DW = 16,
    parameter int IW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] cout,
    input  logic          din_valid,
    output logic          din_ready,
    input  logic [DW-1:0] din_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [IW-1:0] res_idx,
    output logic [DW-1:0] res_val,
    output logic [IW-1:0] res_idx2,
    output logic [DW-1:0] res_val2,
    output logic          busy
);

    import fc_pkg::*;

    state_t        state;
    logic          ready_en;
    logic [IW-1:0] len;
    logic [IW-1:0] cnt;
    entry_t        best;
    entry_t        second;
    entry_t        upd_best;
    entry_t        upd_second;
    logic          accept;

    // ready_en keeps din_ready low through reset and releases it on the first cycle after reset.
    assign din_ready = (state == S_SCAN) ||
                       ((state == S_IDLE) && ready_en && (cout != '0));
    assign accept    = din_valid && din_ready;

    fc_top2_update u_update (
        .best_in    (best),
        .second_in  (second),
        .new_idx    (cnt),
        .new_val    (din_data),
        .best_out   (upd_best),
        .second_out (upd_second)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ready_en  <= 1'b0;
            len       <= '0;
            cnt       <= '0;
            best      <= '0;
            second    <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        len    <= cout;
                        best   <= '{idx: '0, val: din_data};
                        second <= '{idx: NO_IDX, val: NEG_MIN};
                        cnt    <= IW'(1);
                        busy   <= 1'b1;
                        if (cout == IW'(1)) begin
                            state     <= S_RESULT;
                            res_valid <= 1'b1;
                        end else begin
                            state <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    if (accept) begin
                        best   <= upd_best;
                        second <= upd_second;
                        cnt    <= cnt + IW'(1);
                        if (cnt == len - IW'(1)) begin
                            state     <= S_RESULT;
                            res_valid <= 1'b1;
                        end
                    end
                end
                S_RESULT: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Nothing is accepted in S_RESULT, so these hold still until the handshake.
    assign res_idx  = best.idx;
    assign res_val  = best.val;
    assign res_idx2 = second.idx;
    assign res_val2 = second.val;

endmodule

// File: tb/tb_fc_argmax.sv
// Directed bench for fc_argmax with a scoreboard of expected top-2 results, plus a
// short direct check of the fc_top2_update tie rules.
module tb_fc_argmax;

    import fc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] cout = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [15:0] din_data = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [11:0] res_idx;
    logic [15:0] res_val;
    logic [11:0] res_idx2;
    logic [15:0] res_val2;
    logic        busy;

    typedef struct packed {
        logic [11:0] idx;
        logic [15:0] val;
        logic [11:0] idx2;
        logic [15:0] val2;
    } res_t;

    res_t        sb[$];
    logic [15:0] vec[$];
    int          checks = 0;
    int          errors = 0;

    entry_t            ub_in, us_in, ub_out, us_out;
    logic [11:0]       un_idx = '0;
    logic [15:0]       un_val = '0;

    always #5 clk = ~clk;

    fc_argmax #(.DW(16), .IW(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .cout      (cout),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .din_data  (din_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_idx   (res_idx),
        .res_val   (res_val),
        .res_idx2  (res_idx2),
        .res_val2  (res_val2),
        .busy      (busy)
    );

    fc_top2_update u_upd (
        .best_in    (ub_in),
        .second_in  (us_in),
        .new_idx    (un_idx),
        .new_val    (un_val),
        .best_out   (ub_out),
        .second_out (us_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: best is the earliest maximum; second is the earliest maximum of the rest.
    task automatic model();
        int                 bi;
        int                 si;
        logic signed [15:0] sv;
        res_t               r;
        bi = 0;
        for (int i = 1; i < vec.size(); i++)
            if ($signed(vec[i]) > $signed(vec[bi])) bi = i;
        si = -1;
        sv = 16'sh8000;
        for (int i = 0; i < vec.size(); i++)
            if (i != bi && $signed(vec[i]) > sv) begin
                si = i;
                sv = vec[i];
            end
        r.idx  = 12'(bi);
        r.val  = vec[bi];
        r.idx2 = (si < 0) ? 12'hFFF : 12'(si);
        r.val2 = (si < 0) ? 16'h8000 : sv;
        sb.push_back(r);
    endtask

    // Offers vec beats; only a full vector gets an expected result queued.
    task automatic send_vec(input int nbeats, input bit gaps);
        int k;
        int cyc;
        bit acc;
        k   = 0;
        cyc = 0;
        cout = 12'(vec.size());
        if (nbeats == vec.size()) model();
        #1;
        while (k < nbeats && cyc < 400) begin
            din_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            din_data  = vec[k];
            acc = din_valid && din_ready;
            step();
            cyc++;
            if (acc) begin
                k++;
                if (k == 1) cout = 12'(vec.size() + 3);
            end
        end
        din_valid = 1'b0;
        din_data  = 16'hDEAD;
        chk("beats_accepted", k, nbeats);
    endtask

    task automatic get_result(input int hold);
        res_t e;
        int   cyc;
        cyc = 0;
        while (!res_valid && cyc < 50) begin
            step();
            cyc++;
        end
        chk("res_valid", res_valid, 1);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        for (int h = 0; h < hold; h++) begin
            din_valid = 1'b1;
            din_data  = 16'h7777;
            step();
            chk("hold_din_ready", din_ready, 0);
            chk("hold_res_valid", res_valid, 1);
            chk("hold_idx", res_idx, e.idx);
            chk("hold_val", res_val, e.val);
        end
        din_valid = 1'b0;
        chk("res_idx", res_idx, e.idx);
        chk("res_val", res_val, e.val);
        chk("res_idx2", res_idx2, e.idx2);
        chk("res_val2", res_val2, e.val2);
        chk("busy_in_result", busy, 1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("hs_res_valid", res_valid, 0);
        chk("hs_busy", busy, 0);
    endtask

    initial begin
        ub_in  = '0;
        us_in  = '0;
        rst    = 1'b1;
        cout   = '0;
        repeat (3) step();
        chk("rst_din_ready", din_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_idx", res_idx, 0);
        chk("rst_res_val", res_val, 0);
        chk("rst_res_idx2", res_idx2, 0);
        chk("rst_res_val2", res_val2, 0);
        cout = 12'd4;
        rst  = 1'b0;
        step();
        chk("ready_after_rst", din_ready, 1);

        // Distinct values, continuous valid.
        vec = {16'd3, 16'd7, 16'd5, 16'd1};
        send_vec(4, 1'b0);
        chk("latency_t1", res_valid, 1);
        get_result(0);

        // Ties keep the earlier index for both best and second.
        vec = {16'h0400, 16'h0400, 16'h0200, 16'h0400, 16'h0100};
        send_vec(5, 1'b0);
        chk("latency_ties", res_valid, 1);
        get_result(0);

        // Negative values: -2, -5, -1.
        vec = {16'hFFFE, 16'hFFFB, 16'hFFFF};
        send_vec(3, 1'b0);
        chk("latency_neg", res_valid, 1);
        get_result(0);

        // Single-beat vector flags "no second".
        vec = {16'd9};
        send_vec(1, 1'b0);
        chk("latency_len1", res_valid, 1);
        get_result(0);

        // cout == 0 never opens the input.
        cout      = 12'd0;
        din_valid = 1'b1;
        din_data  = 16'd5;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("cout0_din_ready", din_ready, 0);
            chk("cout0_res_valid", res_valid, 0);
            chk("cout0_busy", busy, 0);
        end
        din_valid = 1'b0;

        // Gapped valid, held result, then a back-to-back vector.
        vec = {16'd10, 16'hFFFD, 16'd20, 16'd15};
        send_vec(4, 1'b1);
        chk("latency_gaps", res_valid, 1);
        get_result(5);
        chk("b2b_din_ready", din_ready, 1);
        vec = {16'd8, 16'd2};
        send_vec(2, 1'b0);
        chk("latency_b2b", res_valid, 1);
        get_result(0);

        // Reset in the middle of a vector discards it.
        vec = {16'd4, 16'd9, 16'd3, 16'd11};
        send_vec(2, 1'b0);
        chk("abort_busy", busy, 1);
        rst = 1'b1;
        step();
        chk("abort_din_ready", din_ready, 0);
        chk("abort_busy_clr", busy, 0);
        chk("abort_res_valid", res_valid, 0);
        chk("abort_res_idx", res_idx, 0);
        chk("abort_res_val", res_val, 0);
        rst = 1'b0;
        step();
        chk("abort_ready_again", din_ready, 1);
        vec = {16'd1, 16'd6};
        send_vec(2, 1'b0);
        chk("latency_fresh", res_valid, 1);
        get_result(0);

        // Direct cases for the update block.
        ub_in  = '{idx: 12'd0, val: 16'sd5};
        us_in  = '{idx: 12'd1, val: 16'sd3};
        un_idx = 12'd2;
        un_val = 16'd5;
        #1;
        chk("upd_eq_best_bidx", ub_out.idx, 0);
        chk("upd_eq_best_sidx", us_out.idx, 2);
        chk("upd_eq_best_sval", us_out.val, 5);
        us_in  = '{idx: 12'd2, val: 16'sd5};
        un_idx = 12'd3;
        #1;
        chk("upd_tie_all_bidx", ub_out.idx, 0);
        chk("upd_tie_all_sidx", us_out.idx, 2);
        us_in  = '{idx: 12'd1, val: 16'sd3};
        un_idx = 12'd4;
        un_val = 16'd9;
        #1;
        chk("upd_new_best_bidx", ub_out.idx, 4);
        chk("upd_new_best_bval", ub_out.val, 9);
        chk("upd_new_best_sidx", us_out.idx, 0);
        un_idx = 12'd5;
        un_val = 16'hFFF9;
        #1;
        chk("upd_small_bidx", ub_out.idx, 0);
        chk("upd_small_sidx", us_out.idx, 1);

        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_argmax.md
Name: fc_argmax

Overview:
- Downstream consumer of the fully-connected core's output stream (16-bit signed Q5.10 activations, one per output channel, valid/ready).
- Scans one vector of `cout` beats and reports the top-2 classes (index and value) on a result handshake.
- Sits between the final FC layer and the host/result register interface.
- Frees the upstream core by accepting one beat per cycle with no stalls.

Parameters:
- DW, 16, data width of the activation stream (signed).
- IW, 12, index/count width; matches the FC core's `cout` width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cout  in  IW  vector length; sampled on the first accepted beat of a vector
- din_valid  in  1  upstream data valid
- din_ready  out  1  block can accept a beat
- din_data  in  DW  activation (signed)
- res_valid  out  1  result available
- res_ready  in  1  result consumer accepts
- res_idx  out  IW  index of maximum
- res_val  out  DW  maximum value
- res_idx2  out  IW  index of second maximum
- res_val2  out  DW  second maximum value
- busy  out  1  high from first accepted beat until result handshake completes

Behaviour:
- Reset values: din_ready=0, res_valid=0, busy=0, res_idx=res_idx2=0, res_val=res_val2=0. Internal state: state=S_IDLE, cnt=0.
- The cycle after reset deasserts, din_ready=1.
- Beat accept: `din_valid && din_ready` on a rising edge.
- State machine:
  - S_IDLE: din_ready=1 if cout!=0, else 0.
    - On accept: latch len=cout; best=(idx 0, din_data); second=(idx {IW{1'b1}}, most-negative 16'h8000); cnt=1; busy=1.
    - If len==1, go to S_RESULT; else go to S_SCAN.
  - S_SCAN: din_ready=1.
    - On accept with index i=cnt:
      - If `$signed(din_data) > best.val`: second<=best; best<=(i, din_data).
      - Else if `$signed(din_data) > second.val`: second<=(i, din_data).
      - cnt<=cnt+1.
    - If cnt==len-1 on this accept, go to S_RESULT.
  - S_RESULT: din_ready=0; res_valid=1; outputs driven from best/second registers and held stable until the handshake.
    - On `res_valid && res_ready`: res_valid<=0, busy<=0, go to S_IDLE.
- Comparisons are strict signed greater-than. Ties keep the earlier index, for both best and second.
- An equal value to best does not displace second if it is not greater than second.
- Latency: res_valid rises on the cycle after the last beat is accepted. Throughput is 1 beat/cycle.
- Idle gap between vectors: one cycle in S_RESULT minimum. A back-to-back vector may be accepted the cycle after the result handshake.
- len is held for the whole vector. Changes to cout mid-vector are ignored.
- cout==0: the block never asserts din_ready and produces no result.
- cout==1: res_idx2={IW{1'b1}}, res_val2=16'h8000, flagging "no second".
- din_valid while din_ready=0: ignored. Upstream holds data; no beat is lost.
- rst mid-scan or mid-result: everything returns to reset values immediately and the partial vector is discarded.
- No arithmetic beyond compare. Index counter wraps only if len=4096 (not supported; the cout maximum is 4095).

Decomposition:
- Shared package fc_pkg:
  - DW/IW constants
  - state encoding (S_IDLE=0, S_SCAN=1, S_RESULT=2)
  - NO_IDX={IW{1'b1}}
  - NEG_MIN=16'h8000
- One natural sub-module: fc_top2_update. It is combinational: it takes (best, second, new index, new value) and returns the updated (best, second) with the tie rules above. It is instantiated once and unit-tested separately.

Test Plan:
- cout=4, data 3,7,5,1 continuous valid, res_ready=1 → res_valid on the cycle after the 4th accept; idx=1, val=7, idx2=2, val2=5; busy drops with the handshake.
- cout=5, data 0x0400,0x0400,0x0200,0x0400,0x0100 (ties) → idx=0, val=0x0400, idx2=1, val2=0x0400.
- cout=3, signed data -2,-5,-1 → idx=2, val=-1, idx2=0, val2=-2.
- cout=1, data 9 → idx=0, val=9, idx2=0xFFF, val2=0x8000.
- cout=4 with random din_valid gaps; res_ready low for 5 cycles, then high → din_ready=0 during the hold, outputs stable; the next vector (8,2) is accepted the cycle after the handshake → idx=0, idx2=1.
- Assert rst after 2 of 4 beats, then send a fresh cout=2 vector 1,6 → result idx=1, val=6, idx2=0, val2=1. No stale data from the aborted vector.
